cgra_mem_port_ctrl: RTL and testbench

//  Upstream front-end for one CGRA SRAM bank wrapper. Converts an OBI-style bus port (req/gnt/rvalid)

---
 rtl/cgra_mem_port_pkg.sv | 14 +
 rtl/cgra_mem_port_rsp_pipe.sv | 51 +++++
 rtl/cgra_mem_port_ctrl.sv | 125 ++++++++++++
 tb/tb_cgra_mem_port_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_mem_port_pkg.sv
// Shared types for the CGRA SRAM bank port controller.
package cgra_mem_port_pkg;

  typedef enum logic [1:0] {ACTIVE, DRAIN, RET, WAKE} cgra_mem_port_state_e;

  localparam int unsigned WakeCntWidth = 8;

  // One in-flight response: whether a grant occupies the stage and whether it was a write.
  typedef struct packed {
    logic valid;
    logic we;
  } cgra_mem_port_rsp_t;

endpackage

// File: rtl/cgra_mem_port_rsp_pipe.sv
// Response tracking pipe: one (valid, we) stage per cycle of response latency.
// CGRA_MEM_PORT_RDATA_REG_EN defined: two stages; undefined: one stage.
module cgra_mem_port_rsp_pipe
  import cgra_mem_port_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  cgra_mem_port_rsp_t rsp_i,
  output cgra_mem_port_rsp_t rsp_o,
  output logic               empty_o
);

`ifdef CGRA_MEM_PORT_RDATA_REG_EN
  localparam int unsigned Depth = 2;
`else
  localparam int unsigned Depth = 1;
`endif

  cgra_mem_port_rsp_t [Depth-1:0] stage_q, stage_d;

  // Shift the new grant in at stage 0; older entries move one stage down.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = rsp_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset discards every pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Empty only when no stage holds a grant.
  always_comb begin
    empty_o = 1'b1;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (stage_q[i].valid) begin
        empty_o = 1'b0;
      end
    end
  end

  assign rsp_o = stage_q[Depth-1];

endmodule

// File: rtl/cgra_mem_port_ctrl.sv
// OBI-style bus front-end for one CGRA SRAM bank: single-cycle SRAM strobes,
// fixed-latency responses, and retention entry/exit sequencing.
// CGRA_MEM_PORT_RDATA_REG_EN defined: registered read data, latency 2; undefined: latency 1.
module cgra_mem_port_ctrl
  import cgra_mem_port_pkg::*;
#(
  parameter  int unsigned NUM_WORDS   = 1024,
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned WAKE_CYCLES = 4,
  localparam int unsigned AddrWidth   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned BeWidth     = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BeWidth-1:0]    be_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  ret_req_i,
  output logic                  ret_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AddrWidth-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BeWidth-1:0]    mem_be_o,
  output logic                  mem_set_retentive_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  cgra_mem_port_state_e    state_q, state_d;
  logic [WakeCntWidth-1:0] cnt_q, cnt_d;
  cgra_mem_port_rsp_t      rsp_in, rsp_out;
  logic                    pipe_empty;
  logic                    unused_addr_bits;

  // Requests are accepted only in ACTIVE, and a retention request blocks them.
  assign gnt_o     = (state_q == ACTIVE) & req_i & ~ret_req_i;
  assign mem_req_o = req_i & gnt_o;

  // SRAM side is a straight pass-through of the bus; out-of-range high address bits alias.
  assign mem_we_o         = we_i;
  assign mem_addr_o       = addr_i[AddrWidth+1:2];
  assign mem_wdata_o      = wdata_i;
  assign mem_be_o         = be_i;
  assign unused_addr_bits = ^{addr_i[31:AddrWidth+2], addr_i[1:0]};

  // Retention status decoded straight from the state register.
  assign mem_set_retentive_o = (state_q == RET);
  assign ret_ack_o           = (state_q == RET) | (state_q == WAKE);

  // Retention sequencing and wake-up timer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACTIVE: begin
        if (ret_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!ret_req_i)      state_d = ACTIVE;
        else if (pipe_empty) state_d = RET;
      end
      RET: begin
        if (!ret_req_i) begin
          state_d = WAKE;
          cnt_d   = WakeCntWidth'(WAKE_CYCLES);
        end
      end
      WAKE: begin
        cnt_d = cnt_q - WakeCntWidth'(1);
        if (cnt_q == WakeCntWidth'(1)) state_d = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each grant enters the response pipe tagged with its direction.
  assign rsp_in.valid = gnt_o;
  assign rsp_in.we    = gnt_o & we_i;

  cgra_mem_port_rsp_pipe u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rsp_i   (rsp_in),
    .rsp_o   (rsp_out),
    .empty_o (pipe_empty)
  );

  assign rvalid_o = rsp_out.valid;

`ifdef CGRA_MEM_PORT_RDATA_REG_EN
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  assign rdata_d = mem_rdata_i;

  // Extra output register on SRAM read data; write responses are zeroed after it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = (rsp_out.valid & ~rsp_out.we) ? rdata_q : '0;
`else
  assign rdata_o = (rsp_out.valid & ~rsp_out.we) ? mem_rdata_i : '0;
`endif

endmodule

// File: tb/tb_cgra_mem_port_ctrl.sv
// Directed bench for cgra_mem_port_ctrl with a small SRAM model.
// Latency follows CGRA_MEM_PORT_RDATA_REG_EN (2 when defined, 1 otherwise).
module tb_cgra_mem_port_ctrl;

`ifdef CGRA_MEM_PORT_RDATA_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i, ret_req_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, ret_ack_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o, mem_set_retentive_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  cgra_mem_port_ctrl #(.NUM_WORDS(1024), .DATA_WIDTH(32), .WAKE_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .ret_req_i(ret_req_i), .ret_ack_o(ret_ack_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_set_retentive_o(mem_set_retentive_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM bank model: byte-masked writes, read data one cycle after the strobe.
  logic [31:0] sram [0:1023];
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic        rv_hist [0:1023];
  logic [31:0] rd_hist [0:1023];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
  endtask

  // Advance one clock and record the response outputs seen in the new cycle.
  task automatic step();
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    rv_hist[cyc] = rvalid_o;
    rd_hist[cyc] = rdata_o;
  endtask

  task automatic drive(input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_i = rq; we_i = w; addr_i = a; wdata_i = d; be_i = 4'hF;
    #1;
  endtask

  // Raise ret_req and wait (bounded) for the controller to reach RET.
  task automatic enter_ret(input string tag);
    int n;
    ret_req_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (!ret_ack_o && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(ret_ack_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gw, gr, g, rc, g4, g5, g5b, g6, n;
    int gq [4];

    rst_ni = 1'b0; ret_req_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_ret_ack", 32'(ret_ack_o), 32'd0);
    check("rst_set_ret", 32'(mem_set_retentive_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // 1: write then read of byte address 0x10
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    check("t1_wr_gnt", 32'(gnt_o), 32'd1);
    check("t1_wr_mreq", 32'(mem_req_o), 32'd1);
    check("t1_wr_mwe", 32'(mem_we_o), 32'd1);
    check("t1_wr_addr", 32'(mem_addr_o), 32'd4);
    check("t1_wr_wdata", mem_wdata_o, 32'hDEADBEEF);
    check("t1_wr_be", 32'(mem_be_o), 32'hF);
    gw = cyc;
    step();
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    check("t1_rd_gnt", 32'(gnt_o), 32'd1);
    check("t1_rd_mwe", 32'(mem_we_o), 32'd0);
    check("t1_rd_addr", 32'(mem_addr_o), 32'd4);
    gr = cyc;
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("t1_idle_mreq", 32'(mem_req_o), 32'd0);
    repeat (L) step();
    check("t1_early_rvalid", 32'(rv_hist[gw+L-1]), 32'd0);
    check("t1_wr_rvalid", 32'(rv_hist[gw+L]), 32'd1);
    check("t1_wr_rdata", rd_hist[gw+L], 32'd0);
    check("t1_rd_rvalid", 32'(rv_hist[gr+L]), 32'd1);
    check("t1_rd_rdata", rd_hist[gr+L], 32'hDEADBEEF);

    // 2: fill words 0..3, then four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'(4*i), 32'hA0A00000 + 32'(i));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'(4*i), 32'h0);
      check("t2_gnt", 32'(gnt_o), 32'd1);
      gq[i] = cyc;
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (L) step();
    for (int i = 0; i < 4; i++) begin
      check("t2_rvalid", 32'(rv_hist[gq[0]+L+i]), 32'd1);
      check("t2_rdata", rd_hist[gq[0]+L+i], 32'hA0A00000 + 32'(i));
    end
    check("t2_tail_rvalid", 32'(rv_hist[gq[3]+L+1]), 32'd0);

    // 3: retention request right after a read grant (high address bits alias)
    drive(1'b1, 1'b0, 32'hFFFFF004, 32'h0);
    check("t3_gnt", 32'(gnt_o), 32'd1);
    check("t3_alias_addr", 32'(mem_addr_o), 32'd1);
    g = cyc;
    step();
    ret_req_i = 1'b1;
    drive(1'b1, 1'b0, 32'h8, 32'h0);
    check("t3_ret_blocks_gnt", 32'(gnt_o), 32'd0);
    step();
    check("t3_drain_gnt", 32'(gnt_o), 32'd0);
    check("t3_drain_ack", 32'(ret_ack_o), 32'd0);
    n = 0;
    while (!ret_ack_o && n < 20) begin
      step();
      n++;
    end
    rc = cyc;
    check("t3_ret_entry_cyc", 32'(rc), 32'(g + 2 + L));
    check("t3_ret_ack", 32'(ret_ack_o), 32'd1);
    check("t3_set_ret", 32'(mem_set_retentive_o), 32'd1);
    check("t3_ret_gnt", 32'(gnt_o), 32'd0);
    check("t3_rsp_rvalid", 32'(rv_hist[g+L]), 32'd1);
    check("t3_rsp_rdata", rd_hist[g+L], 32'hA0A00001);
    check("t3_no_blocked_rsp", 32'(rv_hist[g+L+1]), 32'd0);

    // 4: retention exit, four WAKE cycles, grant in the fifth
    ret_req_i = 1'b0;
    drive(1'b1, 1'b0, 32'hC, 32'h0);
    check("t4_ret_exit_gnt", 32'(gnt_o), 32'd0);
    step();
    check("t4_wake_set_ret", 32'(mem_set_retentive_o), 32'd0);
    check("t4_wake_ack", 32'(ret_ack_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      ret_req_i = (i == 1);
      #1;
      check("t4_wake_gnt", 32'(gnt_o), 32'd0);
      step();
    end
    ret_req_i = 1'b0;
    #1;
    check("t4_active_gnt", 32'(gnt_o), 32'd1);
    check("t4_active_ack", 32'(ret_ack_o), 32'd0);
    check("t4_active_addr", 32'(mem_addr_o), 32'd3);
    g4 = cyc;
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (L) step();
    check("t4_rsp_rvalid", 32'(rv_hist[g4+L]), 32'd1);
    check("t4_rsp_rdata", rd_hist[g4+L], 32'hA0A00003);

    // 5: one-cycle retention pulse aborts from DRAIN
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    g5 = cyc;
    step();
    ret_req_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    ret_req_i = 1'b0;
    drive(1'b1, 1'b0, 32'h4, 32'h0);
    check("t5_drain_gnt", 32'(gnt_o), 32'd0);
    check("t5_drain_ack", 32'(ret_ack_o), 32'd0);
    check("t5_drain_set_ret", 32'(mem_set_retentive_o), 32'd0);
    step();
    check("t5_back_gnt", 32'(gnt_o), 32'd1);
    check("t5_back_ack", 32'(ret_ack_o), 32'd0);
    check("t5_back_set_ret", 32'(mem_set_retentive_o), 32'd0);
    g5b = cyc;
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (L) step();
    check("t5_rsp0_rdata", rd_hist[g5+L], 32'hA0A00000);
    check("t5_rsp1_rvalid", 32'(rv_hist[g5b+L]), 32'd1);
    check("t5_rsp1_rdata", rd_hist[g5b+L], 32'hA0A00001);

    // 6a: reset while in RET
    enter_ret("t6_ret_wait_a");
    ret_req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_ret_set_ret", 32'(mem_set_retentive_o), 32'd0);
    check("t6_rst_ret_ack", 32'(ret_ack_o), 32'd0);
    rst_ni = 1'b1;
    step();

    // 6b: reset mid-WAKE
    enter_ret("t6_ret_wait_b");
    ret_req_i = 1'b0;
    #1;
    step();
    step();
    check("t6_mid_wake_ack", 32'(ret_ack_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_wake_ack", 32'(ret_ack_o), 32'd0);
    check("t6_rst_wake_set_ret", 32'(mem_set_retentive_o), 32'd0);
    rst_ni = 1'b1;
    drive(1'b1, 1'b0, 32'h8, 32'h0);
    check("t6_post_rst_gnt", 32'(gnt_o), 32'd1);
    g6 = cyc;
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("t6_post_rst_gnt_low", 32'(gnt_o), 32'd0);

    // 6c: reset while a response is on the bus
    repeat (L - 1) step();
    check("t6_pre_rst_rvalid", 32'(rvalid_o), 32'd1);
    check("t6_pre_rst_rdata", rdata_o, 32'hA0A00002);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_rvalid", 32'(rvalid_o), 32'd0);
    check("t6_rst_rdata", rdata_o, 32'd0);
    rst_ni = 1'b1;
    step();
    check("t6_after_rst_rvalid", 32'(rvalid_o), 32'd0);
    check("t6_g6_seen", 32'(g6 >= 0), 32'(cyc > g6));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
